ringoscillator_tuner: RTL and testbench
=======================================

RINGOSCILLATOR_TUNER -- requirements
Module: ringoscillator_tuner

Interface
REQ-001 SHALL have parameter MAX_TAPS, default 4: number of oscillator taps; must be >= 2.
REQ-002 SHALL have parameter TAPWIDTH, derived as $clog2(MAX_TAPS-1)+1: tap select width.
REQ-003 SHALL have parameter DIV_BITS, default 6: ripple-divider stages in the oscillator domain.
REQ-004 SHALL have parameter WINDOW_BITS, default 12: the measurement window is 2^WINDOW_BITS clk cycles.
REQ-005 SHALL have parameter COUNT_WIDTH, default 12: width of the edge counter and of target.
REQ-006 SHALL have parameter RST_CYCLES, default 4: clk cycles osc_rst is held per tap change.
REQ-007 SHALL have parameter TRACK_HYST, default 8: lower hysteresis band, used only in tracking mode.
REQ-008 SHALL have port clk, input, 1 bit: the single clock.
REQ-009 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-010 SHALL have port start, input, 1 bit: begins a tap search when the block is idle.
REQ-011 SHALL have port target, input, COUNT_WIDTH bits: maximum acceptable edge count per window.
REQ-012 SHALL have port osc_in, input, 1 bit: ring oscillator output, asynchronous to clk.
REQ-013 SHALL have port osc_tap, output, TAPWIDTH bits: drives the oscillator tap select.
REQ-014 SHALL have port osc_rst, output, 1 bit: drives the oscillator reset.
REQ-015 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse at search completion.
REQ-017 SHALL have port locked, output, 1 bit: the last evaluation met target.
REQ-018 SHALL have port count, output, COUNT_WIDTH bits: edge count from the last completed window.

Function
REQ-019 SHALL divide osc_in by 2^DIV_BITS using a ripple counter clocked by osc_in and asynchronously cleared by rst.
REQ-020 SHALL bring the divider MSB into the clk domain through 3 flip-flops and count its rising edges.
REQ-021 SHALL require the divided frequency to be below clk/2; faster input is out of spec.
REQ-022 SHALL implement the FSM IDLE -> HOLD -> WARM -> MEASURE -> EVAL, followed by HOLD again or DONE.
- IDLE: start=1 loads osc_tap=0 and enters HOLD.
- HOLD: osc_rst=1 for exactly RST_CYCLES cycles, then WARM.
- WARM: osc_rst=0 for 8 cycles so the synchronizer flushes; edges in WARM are discarded.
- MEASURE: runs 2^WINDOW_BITS cycles; the edge counter clears on entry and saturates at all-ones.
- EVAL: 1 cycle; count is updated to the counter value.
  - counter <= target: locked=1, go to DONE.
  - otherwise, if osc_tap < MAX_TAPS-1: osc_tap+1, go to HOLD.
  - otherwise: locked=0, go to DONE with osc_tap held at MAX_TAPS-1.
- DONE: done=1 for one cycle, then IDLE; the oscillator is left running at osc_tap with osc_rst=0.
REQ-023 SHALL take exactly RST_CYCLES+8+2^WINDOW_BITS+1 clk cycles per tap trial.
REQ-024 SHALL ignore start in any state other than IDLE.
REQ-025 SHALL sample target only in EVAL; target changes at other times have no effect.
REQ-026 SHALL change osc_tap only while osc_rst=1 (HOLD entry) or from IDLE with start.

Reset
REQ-027 SHALL on rst=1 set state=IDLE, osc_tap=0, osc_rst=1, busy=0, done=0, locked=0, count=0, and clear the divider and synchronizer.
REQ-028 SHALL on rst mid-search abort immediately with no done pulse; the oscillator stays stopped until the next start.

Configuration
REQ-029 SHALL compile in tracking mode only when macro RINGOSC_TUNER_TRACK_EN is defined.
- Without the macro: behaviour is exactly as REQ-022.
- With the macro: after DONE the FSM re-enters WARM, not IDLE, and measures continuously until rst.
- Each tracking EVAL steps the tap:
  - count > target and osc_tap < MAX_TAPS-1: osc_tap+1 via HOLD.
  - count < target-TRACK_HYST and osc_tap > 0: osc_tap-1 via HOLD.
  - otherwise: keep the tap, return to WARM.
- In tracking, locked = (count <= target), updated every EVAL; done is not pulsed again; busy stays 1.

Verification
Bench setup: clk 12 MHz; osc model per tap 192/144/96/48 MHz, giving expected counts 1024/768/512/256 (+-1).
REQ-030 SHALL cover target=600, start pulse -> taps 0,1,2 tried; done after 3*4109 cycles; osc_tap=2, locked=1, count=512+-1.
REQ-031 SHALL cover target=2000 -> done after 4109 cycles; osc_tap=0, locked=1, count=1024+-1.
REQ-032 SHALL cover target=100 -> all 4 taps tried; osc_tap=3, locked=0, count=256+-1.
REQ-033 SHALL cover start re-pulsed during MEASURE, then rst asserted mid-HOLD -> the start is ignored; after rst, outputs match REQ-027 with no done pulse.
REQ-034 SHALL cover osc_rst: high exactly RST_CYCLES cycles around each tap change; osc_tap is stable whenever osc_rst=0.
REQ-035 SHALL cover RINGOSC_TUNER_TRACK_EN: locked at tap 2 with target=600, then the model's tap-2 frequency drops to 60 MHz (count 320 < 592) -> next EVAL moves to osc_tap=1.

Source files
------------

// File: rtl/ringoscillator_tuner.sv
// rtl/ringoscillator_tuner.sv - ring oscillator tap search; tracking mode when RINGOSC_TUNER_TRACK_EN is defined
`timescale 1ps/1ps
module ringoscillator_tuner #(
   parameter int MAX_TAPS    = 4,
   parameter int TAPWIDTH    = $clog2(MAX_TAPS-1)+1,
   parameter int DIV_BITS    = 6,
   parameter int WINDOW_BITS = 12,
   parameter int COUNT_WIDTH = 12,
   parameter int RST_CYCLES  = 4,
   parameter int TRACK_HYST  = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [COUNT_WIDTH-1:0] target,
   input  logic                   osc_in,
   output logic [TAPWIDTH-1:0]    osc_tap,
   output logic                   osc_rst,
   output logic                   busy,
   output logic                   done,
   output logic                   locked,
   output logic [COUNT_WIDTH-1:0] count
);

   // One shared phase timer covers HOLD, WARM and the measurement window.
   localparam int HOLD_W  = $clog2(RST_CYCLES) + 1;
   localparam int BASE_W  = (WINDOW_BITS > HOLD_W) ? WINDOW_BITS : HOLD_W;
   localparam int TIMER_W = (BASE_W > 4) ? BASE_W : 4;

   localparam logic [TIMER_W-1:0]   HOLD_LAST = TIMER_W'(RST_CYCLES - 1);
   localparam logic [TIMER_W-1:0]   WARM_LAST = TIMER_W'(7);
   localparam logic [TIMER_W-1:0]   MEAS_LAST = TIMER_W'((1 << WINDOW_BITS) - 1);
   localparam logic [TAPWIDTH-1:0]  TAP_LAST  = TAPWIDTH'(MAX_TAPS - 1);
`ifdef RINGOSC_TUNER_TRACK_EN
   localparam logic [COUNT_WIDTH:0] HYST      = (COUNT_WIDTH+1)'(TRACK_HYST);
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_HOLD,
      S_WARM,
      S_MEASURE,
      S_EVAL,
      S_DONE
   } state_t;

   state_t                 state;
   logic [TIMER_W-1:0]     timer;
   logic [COUNT_WIDTH-1:0] edge_cnt;
   logic [DIV_BITS-1:0]    div_q;
   logic [2:0]             sync_q;
   logic                   div_rise;
`ifdef RINGOSC_TUNER_TRACK_EN
   logic                   tracking;
`endif

   // Ripple divider in the oscillator domain: each stage toggles on the fall of the one before.
   genvar gi;
   generate
      for (gi = 0; gi < DIV_BITS; gi++) begin : g_div
         logic stage_q;
         if (gi == 0) begin : g_first
            // First stage toggles on every oscillator rising edge.
            always_ff @(posedge osc_in or posedge rst) begin
               if (rst) stage_q <= 1'b0;
               else     stage_q <= ~stage_q;
            end
         end else begin : g_next
            // Later stages toggle when the previous stage wraps to zero.
            always_ff @(negedge div_q[gi-1] or posedge rst) begin
               if (rst) stage_q <= 1'b0;
               else     stage_q <= ~stage_q;
            end
         end
         assign div_q[gi] = stage_q;
      end
   endgenerate

   // Two flops resolve metastability on the divider MSB, the third gives the edge reference.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= 3'b000;
      else     sync_q <= {sync_q[1:0], div_q[DIV_BITS-1]};
   end

   assign div_rise = sync_q[1] & ~sync_q[2];

   // Search sequencer: owns the timer, the edge counter and every registered output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         timer    <= '0;
         edge_cnt <= '0;
         osc_tap  <= '0;
         osc_rst  <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         locked   <= 1'b0;
         count    <= '0;
`ifdef RINGOSC_TUNER_TRACK_EN
         tracking <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  osc_tap <= '0;
                  osc_rst <= 1'b1;
                  busy    <= 1'b1;
                  timer   <= '0;
                  state   <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (timer == HOLD_LAST) begin
                  osc_rst <= 1'b0;
                  timer   <= '0;
                  state   <= S_WARM;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_WARM: begin
               if (timer == WARM_LAST) begin
                  edge_cnt <= '0;
                  timer    <= '0;
                  state    <= S_MEASURE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_MEASURE: begin
               if (div_rise && edge_cnt != '1) edge_cnt <= edge_cnt + 1'b1;
               timer <= timer + 1'b1;
               if (timer == MEAS_LAST) state <= S_EVAL;
            end
            S_EVAL: begin
               count  <= edge_cnt;
               locked <= (edge_cnt <= target);
               timer  <= '0;
`ifdef RINGOSC_TUNER_TRACK_EN
               if (tracking) begin
                  if (edge_cnt > target && osc_tap != TAP_LAST) begin
                     osc_tap <= osc_tap + 1'b1;
                     osc_rst <= 1'b1;
                     state   <= S_HOLD;
                  end else if (({1'b0, edge_cnt} + HYST) < {1'b0, target} && osc_tap != '0) begin
                     osc_tap <= osc_tap - 1'b1;
                     osc_rst <= 1'b1;
                     state   <= S_HOLD;
                  end else begin
                     state <= S_WARM;
                  end
               end else if (edge_cnt <= target || osc_tap == TAP_LAST) begin
`else
               if (edge_cnt <= target || osc_tap == TAP_LAST) begin
`endif
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  osc_tap <= osc_tap + 1'b1;
                  osc_rst <= 1'b1;
                  state   <= S_HOLD;
               end
            end
            S_DONE: begin
               done <= 1'b0;
`ifdef RINGOSC_TUNER_TRACK_EN
               tracking <= 1'b1;
               state    <= S_WARM;
`else
               busy  <= 1'b0;
               state <= S_IDLE;
`endif
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ringoscillator_tuner.sv
// tb/tb_ringoscillator_tuner.sv - self-checking bench for ringoscillator_tuner
`timescale 1ps/1ps
module tb_ringoscillator_tuner;

   localparam int MAX_TAPS    = 4;
   localparam int TAPWIDTH    = 3;
   localparam int COUNT_WIDTH = 12;
   localparam int RST_CYCLES  = 4;
   localparam int TRIAL       = RST_CYCLES + 8 + 4096 + 1;
   localparam int CLK_HALF    = 41667;

   logic                   clk    = 1'b0;
   logic                   rst    = 1'b1;
   logic                   start  = 1'b0;
   logic [COUNT_WIDTH-1:0] target = '0;
   logic                   osc_in;
   logic [TAPWIDTH-1:0]    osc_tap;
   logic                   osc_rst;
   logic                   busy;
   logic                   done;
   logic                   locked;
   logic [COUNT_WIDTH-1:0] count;

   int total = 0;
   int bad   = 0;

   // oscillator half periods per tap: 192/144/96/48 MHz
   int half_ps [MAX_TAPS] = '{2604, 3472, 5208, 10417};

   // model state
   int  k        = 0;
   int  m_trials = 1;
   int  m_target = 0;
   bit  p_orst   = 1'b1;
   int  p_tap    = 0;
   real p_cnt    = 0.0;
   bit  p_exact  = 1'b1;
   bit  p_locked = 1'b0;
   int  done_k   = 0;
   int  done_cnt = 0;
   int  cn, cp, ce;
   logic                last_orst;
   logic [TAPWIDTH-1:0] last_tap;

   ringoscillator_tuner dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .target  (target),
      .osc_in  (osc_in),
      .osc_tap (osc_tap),
      .osc_rst (osc_rst),
      .busy    (busy),
      .done    (done),
      .locked  (locked),
      .count   (count)
   );

   always #CLK_HALF clk = ~clk;

   always begin
      if (osc_rst !== 1'b0) begin
         osc_in = 1'b0;
         wait (osc_rst === 1'b0);
      end else begin
         #(half_ps[osc_tap]) osc_in = ~osc_in;
      end
   end

   function automatic real exp_count(input int tap);
      return (4096.0 * 2.0 * CLK_HALF) / (64.0 * 2.0 * half_ps[tap]);
   endfunction

   function automatic int trials_for(input int tgt);
      for (int n = 0; n < MAX_TAPS; n++)
         if (exp_count(n) <= tgt) return n + 1;
      return MAX_TAPS;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at k=%0d t=%0t", name, act, want, k, $time);
      end
   endtask

   task automatic chk_cnt(input string name, input logic [COUNT_WIDTH-1:0] act, input real want, input bit exact);
      real d;
      bit  ok;
      total++;
      if ($isunknown(act)) ok = 1'b0;
      else if (exact) ok = (real'(act) == want);
      else begin
         d = real'(act) - want;
         if (d < 0.0) d = -d;
         ok = (d <= 1.0);
      end
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %0d want %0.1f (+-%0d) at k=%0d", name, act, want, exact ? 0 : 1, k);
      end
   endtask

`ifndef RINGOSC_TUNER_TRACK_EN
   // timeline model: cycle k after the accepted start decides every output
   always @(negedge clk) begin
      if (rst) begin
         k = 0; p_orst = 1'b1; p_tap = 0; p_cnt = 0.0; p_exact = 1'b1; p_locked = 1'b0;
      end else if (k == 0 && start) begin
         k = 1;
      end else if (k > 0) begin
         k++;
      end
      if (k > m_trials * TRIAL + 1) begin
         k = 0; p_orst = 1'b0; p_tap = m_trials - 1;
         p_cnt = exp_count(m_trials - 1); p_exact = 1'b0;
         p_locked = (exp_count(m_trials - 1) <= m_target);
      end
      if (done === 1'b1) begin
         done_k = k;
         done_cnt++;
      end
      if (k == 0) begin
         chk("idle_busy", busy, 0);
         chk("idle_done", done, 0);
         chk("idle_osc_rst", osc_rst, p_orst);
         chk("idle_osc_tap", osc_tap, p_tap);
         chk("idle_locked", locked, p_locked);
         chk_cnt("idle_count", count, p_cnt, p_exact);
      end else begin
         cn = (k - 1) / TRIAL;
         cp = (k - 1) % TRIAL;
         ce = cn - 1;
         chk("run_busy", busy, 1);
         if (cn >= m_trials) begin
            chk("done_pulse", done, 1);
            chk("done_osc_rst", osc_rst, 0);
            chk("done_osc_tap", osc_tap, m_trials - 1);
         end else begin
            chk("run_done", done, 0);
            chk("run_osc_rst", osc_rst, (cp < RST_CYCLES) ? 1 : 0);
            chk("run_osc_tap", osc_tap, cn);
         end
         if (ce >= 0) begin
            chk_cnt("run_count", count, exp_count(ce), 1'b0);
            chk("run_locked", locked, (exp_count(ce) <= m_target) ? 1 : 0);
         end else begin
            chk_cnt("run_count_prev", count, p_cnt, p_exact);
            chk("run_locked_prev", locked, p_locked);
         end
      end
      if (last_orst === 1'b0 && osc_rst === 1'b0)
         chk("tap_stable", osc_tap, last_tap);
      last_orst = osc_rst;
      last_tap  = osc_tap;
   end
`endif

   task automatic wait_k(input int want);
      int c;
      c = 0;
      while (k != want && c < 6 * TRIAL) begin
         @(posedge clk);
         c++;
      end
      total++;
      if (k != want) begin
         bad++;
         $display("FAIL wait_k: got k=%0d want k=%0d", k, want);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk); #1 start = 1'b1;
      @(negedge clk); #1 start = 1'b0;
   endtask

   task automatic begin_search(input int tgt);
      @(negedge clk); #1;
      target   = tgt[COUNT_WIDTH-1:0];
      m_target = tgt;
      m_trials = trials_for(tgt);
      start    = 1'b1;
      @(negedge clk); #1 start = 1'b0;
   endtask

   task automatic run_search(input int tgt, input bit spurious);
      begin_search(tgt);
      if (spurious) begin
         wait_k(1000);
         #1 target = COUNT_WIDTH'($urandom);
         wait_k(2000);
         pulse_start();
         wait_k(3000);
         #1 target = tgt[COUNT_WIDTH-1:0];
      end
      wait_k(0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
`ifndef RINGOSC_TUNER_TRACK_EN
      int tgt;
      int dc;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_osc_rst", osc_rst, 1);
      chk("rst_osc_tap", osc_tap, 0);
      chk("rst_busy", busy, 0);
      chk("rst_count", count, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      run_search(600, 1'b1);
      #1;
      chk("t600_trials", m_trials, 3);
      chk("t600_done_at", done_k, 3 * TRIAL + 1);
      chk("t600_tap", osc_tap, 2);
      chk("t600_locked", locked, 1);
      chk_cnt("t600_count", count, 512.0, 1'b0);

      run_search(2000, 1'b0);
      #1;
      chk("t2000_done_at", done_k, TRIAL + 1);
      chk("t2000_tap", osc_tap, 0);
      chk("t2000_locked", locked, 1);
      chk_cnt("t2000_count", count, 1024.0, 1'b0);

      run_search(100, 1'b0);
      #1;
      chk("t100_done_at", done_k, 4 * TRIAL + 1);
      chk("t100_tap", osc_tap, 3);
      chk("t100_locked", locked, 0);
      chk_cnt("t100_count", count, 256.0, 1'b0);

      dc = done_cnt;
      begin_search(600);
      wait_k(2000);
      pulse_start();
      wait_k(TRIAL + 1);
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("abort_osc_rst", osc_rst, 1);
      chk("abort_osc_tap", osc_tap, 0);
      chk("abort_busy", busy, 0);
      chk("abort_locked", locked, 0);
      chk("abort_count", count, 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("abort_no_done", done_cnt, dc);

      for (int r = 0; r < 2; r++) begin
         if ($urandom_range(0, 1) == 1) tgt = $urandom_range(772, 1020);
         else                           tgt = $urandom_range(1028, 4000);
         run_search(tgt, $urandom_range(0, 1) == 1);
         #1;
         chk("rnd_tap", osc_tap, trials_for(tgt) - 1);
         chk("rnd_locked", locked, 1);
      end
`else
      int c;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_osc_rst", osc_rst, 1);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      #1 target = 12'd600;
      pulse_start();
      c = 0;
      while (done !== 1'b1 && c < 5 * TRIAL) begin
         @(negedge clk);
         c++;
      end
      chk("trk_done_seen", done, 1);
      chk("trk_tap", osc_tap, 2);
      chk("trk_locked", locked, 1);
      chk_cnt("trk_count", count, 512.0, 1'b0);
      half_ps[2] = 8333;
      c = 0;
      while (osc_tap === 3'd2 && c < 3 * TRIAL) begin
         @(negedge clk);
         if (done === 1'b1) chk("trk_no_done", done, 0);
         c++;
      end
      chk("trk_new_tap", osc_tap, 1);
      chk("trk_osc_rst", osc_rst, 1);
      chk("trk_busy", busy, 1);
      chk("trk_locked2", locked, 1);
      chk_cnt("trk_count2", count, 320.0, 1'b0);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
